// File: rtl/mpc_constraint_temp_gen.sv
// Computes temp[i] = sat((G[i,:]·z >>> FracBits) - h[i]) and writes one word per row into the temp RAM.
// Latency NumCols+2 cycles per row; no backpressure, start is ignored unless in IDLE.
module mpc_constraint_temp_gen #(
  parameter int DataWidth    = 21,
  parameter int FracBits     = 12,
  parameter int NumRows      = 6,
  parameter int NumCols      = 2,
  parameter int AddressWidth = 3,
  parameter int ZAddrWidth   = 1,
  parameter int GAddrWidth   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    ready,
  output logic                    done,
  output logic [GAddrWidth-1:0]   g_address0,
  output logic                    g_ce0,
  input  logic [DataWidth-1:0]    g_q0,
  output logic [ZAddrWidth-1:0]   z_address0,
  output logic                    z_ce0,
  input  logic [DataWidth-1:0]    z_q0,
  output logic [AddressWidth-1:0] h_address0,
  output logic                    h_ce0,
  input  logic [DataWidth-1:0]    h_q0,
  output logic [AddressWidth-1:0] temp_address0,
  output logic                    temp_ce0,
  output logic                    temp_we0,
  output logic [DataWidth-1:0]    temp_d0
);

  localparam int ProdWidth = 2 * DataWidth;
  localparam int AccWidth  = ProdWidth + $clog2(NumCols);

  typedef enum logic [2:0] {IDLE, MAC, TAIL, WR, DONE} state_t;

  state_t                       state, state_nxt;
  logic [AddressWidth-1:0]      row;
  logic [ZAddrWidth-1:0]        col;
  logic [GAddrWidth-1:0]        g_ptr;
  logic                         prod_vld;
  logic signed [AccWidth-1:0]   acc;

  logic                         last_col, last_row;
  logic signed [ProdWidth-1:0]  g_ext, z_ext, prod;
  logic signed [AccWidth-1:0]   shifted, h_ext, diff;
  logic                         fits;
  logic [DataWidth-1:0]         sat_val;

  assign last_col = (col == ZAddrWidth'(NumCols - 1));
  assign last_row = (row == AddressWidth'(NumRows - 1));

  assign g_ext = ProdWidth'($signed(g_q0));
  assign z_ext = ProdWidth'($signed(z_q0));
  assign prod  = g_ext * z_ext;

  // Subtraction at accumulator width, then clamp if the result leaves the DataWidth range.
  assign shifted = acc >>> FracBits;
  assign h_ext   = AccWidth'($signed(h_q0));
  assign diff    = shifted - h_ext;
  assign fits    = (&diff[AccWidth-1:DataWidth-1]) | ~(|diff[AccWidth-1:DataWidth-1]);
  assign sat_val = fits ? diff[DataWidth-1:0]
                 : (diff[AccWidth-1] ? {1'b1, {(DataWidth-1){1'b0}}}
                                     : {1'b0, {(DataWidth-1){1'b1}}});

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = MAC;
      MAC:  if (last_col) state_nxt = TAIL;
      TAIL: state_nxt = WR;
      WR:   state_nxt = last_row ? DONE : MAC;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      g_ptr    <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      state    <= state_nxt;
      prod_vld <= (state == MAC);
      if (prod_vld) acc <= acc + AccWidth'(prod);
      case (state)
        IDLE: if (start) begin
          row   <= '0;
          col   <= '0;
          g_ptr <= '0;
          acc   <= '0;
        end
        MAC: begin
          // G is row-major, so a running pointer walks i*NumCols+j across rows.
          col   <= last_col ? '0 : col + 1'b1;
          g_ptr <= g_ptr + 1'b1;
        end
        WR: begin
          acc <= '0;
          if (!last_row) row <= row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ready         = (state == IDLE);
    done          = (state == DONE);
    g_ce0         = (state == MAC);
    z_ce0         = (state == MAC);
    g_address0    = (state == MAC) ? g_ptr : '0;
    z_address0    = (state == MAC) ? col : '0;
    h_ce0         = (state == TAIL);
    h_address0    = (state == TAIL) ? row : '0;
    temp_ce0      = (state == WR);
    temp_we0      = (state == WR);
    temp_address0 = (state == WR) ? row : '0;
    temp_d0       = (state == WR) ? sat_val : '0;
  end

endmodule

// File: doc/mpc_constraint_temp_gen.md
# mpc_constraint_temp_gen

Produces the constraint-residual vector temp[i] = (G[i,:]·z >>> FracBits) − h[i] for the dense MPC solver and writes it row by row into the constraint_temp single-port RAM, one word per row. It sits directly upstream of that RAM: it drives the RAM's address/ce/we/d port and reads its operands from the G ROM, the z RAM and the h ROM. The downstream projection stage reads the RAM only after `done`.

## Interface
- DataWidth, 21, signed fixed-point word width of G, z, h and temp
- FracBits, 12, fractional bits of the fixed-point format (1.0 = 4096)
- NumRows, 6, constraint rows (temp RAM depth)
- NumCols, 2, decision-vector length
- AddressWidth, 3, temp/h address width
- ZAddrWidth, 1, z address width
- GAddrWidth, 4, G address width (row-major, index i*NumCols+j)

- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  begin a pass; sampled only in IDLE
- ready  out  1  high exactly when in IDLE
- done  out  1  one-cycle pulse after the last row is written
- g_address0 / g_ce0  out  GAddrWidth / 1  G ROM read port
- g_q0  in  DataWidth  G data, valid the cycle after g_ce0
- z_address0 / z_ce0  out  ZAddrWidth / 1  z RAM read port
- z_q0  in  DataWidth  z data, valid the cycle after z_ce0
- h_address0 / h_ce0  out  AddressWidth / 1  h ROM read port
- h_q0  in  DataWidth  h data, valid the cycle after h_ce0
- temp_address0 / temp_ce0 / temp_we0  out  AddressWidth / 1 / 1  constraint_temp write port
- temp_d0  out  DataWidth  result word

## Operation
- States: IDLE, MAC, TAIL, WR, DONE.
- IDLE: all ce/we low. On start=1, clear the row counter i and the accumulator, then go to MAC.
- MAC: issue g_address0=i*NumCols+j and z_address0=j with g_ce0=z_ce0=1, for j=0..NumCols−1, one per cycle. When the last j is issued, go to TAIL.
- Products: a registered valid flag marks returning data. One cycle after each issue, acc += g_q0*z_q0.
  - Each product is a full 2*DataWidth signed value.
  - The accumulator is 2*DataWidth+clog2(NumCols) bits wide and never overflows.
- TAIL: issue h_address0=i with h_ce0=1. The last product is accumulated this cycle.
- WR: assert temp_ce0=temp_we0=1 with temp_address0=i.
  - temp_d0 = sat(acc >>> FracBits − h_q0).
  - The shift is arithmetic (floor toward −∞).
  - The subtraction is done at accumulator width.
  - sat clamps to [−2^(DataWidth−1), 2^(DataWidth−1)−1].
  - After WR, clear acc. If i=NumRows−1, go to DONE; otherwise increment i and return to MAC.
- DONE: done=1 for one cycle, then IDLE.
- start while not in IDLE is ignored; it is neither queued nor restarts the pass.
- temp_we0 is never asserted outside WR. Exactly NumRows writes occur per pass, to addresses 0..NumRows−1 in order.

## Timing
- Reset values: state IDLE, ready=1, done=0, and every ce/we/address/d output 0. acc, i and the valid flag are all 0.
- Reset mid-pass returns to IDLE immediately. No further writes occur, and rows already written are left as is.
- Let start be sampled at edge E0.
  - The first MAC cycle follows E0.
  - Each row takes NumCols+2 cycles.
  - done is high in cycle NumRows*(NumCols+2)+1 after E0.
  - With the default parameters, done is high 25 cycles after E0.
- Row i write occurs in cycle (i+1)*(NumCols+2) after E0. With defaults these are cycles 4, 8, …, 24.
- ready drops the cycle after E0 and returns the cycle after done.
- start held high continuously triggers back-to-back passes separated by exactly one IDLE cycle.
- Operand memories must have exactly one cycle of read latency; read data is never used in the same cycle it is requested.

## Test plan
- Reset behaviour: assert reset low mid-pass at cycle 10 → all outputs 0 and ready=1 on the next edge; no temp write after reset.
- Basic pass: G row0=[4096,0], z=[8192,100], h0=1024; all other G rows 0, h=0 → temp[0]=7168, temp[1..5]=0, written at cycles 4, 8, …, 24 after E0; done at cycle 25.
- Negative/floor: G row1=[−4096,4096], z=[3,1], h1=0 → acc=−8192 → temp[1]=−2. G row2=[1,0], z0=−1 → temp[2]=−1 (floor, not 0).
- Saturation: G row3=[1048575,1048575], z=[1048575,1048575], h3=−1048576 → temp[3]=1048575. The mirrored negative case → −1048576.
- Start-while-busy: pulse start at E0 and again at cycle 7 → exactly 6 writes and 1 done, then ready=1.
- Continuous start: hold start=1 for 60 cycles → two complete passes, done at cycles 25 and 51, identical temp contents.
